// File: rtl/cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_boot_sequencer
// Purpose  : Load-and-run controller in front of the cpu top level. Streams
//            words into instruction memory, then into data memory, through
//            the external write ports. It then enables the cpu for a
//            programmed number of cycles and flags completion. While not
//            idle it is the only driver of the external memory ports.
// Ports    : clk, arst_n            clock, asynchronous active-low reset
//            start, abort          sequence control (abort has priority)
//            imem_len, dmem_len,   phase lengths, latched at start
//            run_len
//            s_valid/s_ready/s_data  input word stream
//            addr_ext/wen_ext/wdata_ext        imem write port (byte addr)
//            addr_ext_2/wen_ext_2/wdata_ext_2  dmem write port (byte addr)
//            cpu_enable, busy, done            status / cpu control
// Revision : 1.0 - initial release
// ============================================================================
module cpu_boot_sequencer #(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [IMEM_ADDR_W:0]   imem_len,
    input  logic [DMEM_ADDR_W:0]   dmem_len,
    input  logic [CNT_W-1:0]       run_len,
    input  logic                   s_valid,
    input  logic [63:0]            s_data,
    output logic                   s_ready,
    output logic [63:0]            addr_ext,
    output logic                   wen_ext,
    output logic [31:0]            wdata_ext,
    output logic [63:0]            addr_ext_2,
    output logic                   wen_ext_2,
    output logic [63:0]            wdata_ext_2,
    output logic                   cpu_enable,
    output logic                   busy,
    output logic                   done
);

    // One word index serves both load phases, so it is sized for the larger.
    localparam int c_idx_w = (IMEM_ADDR_W > DMEM_ADDR_W) ? IMEM_ADDR_W : DMEM_ADDR_W;
    localparam int c_len_w = c_idx_w + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_I = 3'd1,
        S_LOAD_D = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [IMEM_ADDR_W:0]   r_imem_len,  w_imem_len_nxt;
    logic [DMEM_ADDR_W:0]   r_dmem_len,  w_dmem_len_nxt;
    logic [CNT_W-1:0]       r_run_len,   w_run_len_nxt;
    logic [c_idx_w-1:0]     r_idx,       w_idx_nxt;
    logic [CNT_W-1:0]       r_cnt,       w_cnt_nxt;

    logic                   r_s_ready;
    logic [63:0]            r_addr,      w_addr_nxt;
    logic                   r_wen,       w_wen_nxt;
    logic [31:0]            r_wdata,     w_wdata_nxt;
    logic [63:0]            r_addr_2,    w_addr_2_nxt;
    logic                   r_wen_2,     w_wen_2_nxt;
    logic [63:0]            r_wdata_2,   w_wdata_2_nxt;
    logic                   r_cpu_enable;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_accept;
    logic [c_len_w-1:0]     w_idx_inc;
    logic [IMEM_ADDR_W:0]   w_imem_len_clamp;
    logic [DMEM_ADDR_W:0]   w_dmem_len_clamp;

    // r_s_ready mirrors "state is a load phase", so it is a valid handshake term.
    assign w_accept  = s_valid & r_s_ready;
    assign w_idx_inc = {1'b0, r_idx} + c_len_w'(1);

    // Any length with the top bit set exceeds the memory; clamp to full size.
    assign w_imem_len_clamp = imem_len[IMEM_ADDR_W] ? {1'b1, {IMEM_ADDR_W{1'b0}}} : imem_len;
    assign w_dmem_len_clamp = dmem_len[DMEM_ADDR_W] ? {1'b1, {DMEM_ADDR_W{1'b0}}} : dmem_len;

    always_comb begin
        w_state_nxt    = r_state;
        w_imem_len_nxt = r_imem_len;
        w_dmem_len_nxt = r_dmem_len;
        w_run_len_nxt  = r_run_len;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_wen_nxt      = 1'b0;
        w_wen_2_nxt    = 1'b0;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_addr_2_nxt   = r_addr_2;
        w_wdata_2_nxt  = r_wdata_2;

        if (abort) begin
            // Returning to idle also drops any write from a beat taken this cycle.
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_imem_len_nxt = w_imem_len_clamp;
                        w_dmem_len_nxt = w_dmem_len_clamp;
                        w_run_len_nxt  = run_len;
                        w_idx_nxt      = '0;
                        if (w_imem_len_clamp != '0) begin
                            w_state_nxt = S_LOAD_I;
                        end else if (w_dmem_len_clamp != '0) begin
                            w_state_nxt = S_LOAD_D;
                        end else if (run_len != '0) begin
                            w_state_nxt = S_RUN;
                            w_cnt_nxt   = run_len;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (w_accept) begin
                        w_wen_nxt   = 1'b1;
                        w_addr_nxt  = 64'(r_idx[IMEM_ADDR_W-1:0]) << 2;
                        w_wdata_nxt = s_data[31:0];
                        if (w_idx_inc == c_len_w'(r_imem_len)) begin
                            w_idx_nxt = '0;
                            if (r_dmem_len != '0) begin
                                w_state_nxt = S_LOAD_D;
                            end else if (r_run_len != '0) begin
                                w_state_nxt = S_RUN;
                                w_cnt_nxt   = r_run_len;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_idx_nxt = w_idx_inc[c_idx_w-1:0];
                        end
                    end
                end
                S_LOAD_D: begin
                    if (w_accept) begin
                        w_wen_2_nxt   = 1'b1;
                        w_addr_2_nxt  = 64'(r_idx[DMEM_ADDR_W-1:0]) << 3;
                        w_wdata_2_nxt = s_data;
                        if (w_idx_inc == c_len_w'(r_dmem_len)) begin
                            w_idx_nxt = '0;
                            if (r_run_len != '0) begin
                                w_state_nxt = S_RUN;
                                w_cnt_nxt   = r_run_len;
                            end else begin
                                w_state_nxt = S_DONE;
                            end
                        end else begin
                            w_idx_nxt = w_idx_inc[c_idx_w-1:0];
                        end
                    end
                end
                S_RUN: begin
                    // r_cnt holds the enabled cycles remaining including this one.
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_imem_len   <= '0;
            r_dmem_len   <= '0;
            r_run_len    <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_s_ready    <= 1'b0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_addr_2     <= '0;
            r_wen_2      <= 1'b0;
            r_wdata_2    <= '0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_imem_len   <= w_imem_len_nxt;
            r_dmem_len   <= w_dmem_len_nxt;
            r_run_len    <= w_run_len_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_s_ready    <= (w_state_nxt == S_LOAD_I) || (w_state_nxt == S_LOAD_D);
            r_addr       <= w_addr_nxt;
            r_wen        <= w_wen_nxt;
            r_wdata      <= w_wdata_nxt;
            r_addr_2     <= w_addr_2_nxt;
            r_wen_2      <= w_wen_2_nxt;
            r_wdata_2    <= w_wdata_2_nxt;
            r_cpu_enable <= (w_state_nxt == S_RUN);
            r_busy       <= (w_state_nxt == S_LOAD_I) || (w_state_nxt == S_LOAD_D) ||
                            (w_state_nxt == S_RUN);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    assign s_ready     = r_s_ready;
    assign addr_ext    = r_addr;
    assign wen_ext     = r_wen;
    assign wdata_ext   = r_wdata;
    assign addr_ext_2  = r_addr_2;
    assign wen_ext_2   = r_wen_2;
    assign wdata_ext_2 = r_wdata_2;
    assign cpu_enable  = r_cpu_enable;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cpu_boot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_boot_sequencer
// Purpose  : Self-checking bench for cpu_boot_sequencer. A table of load/run
//            scenarios with hand-computed write and enable counts is applied
//            in a loop; every write pulse is checked against its expected
//            address, data and one-cycle latency. Hand-written sequences
//            cover reset state, empty sequence timing, abort and
//            asynchronous reset during RUN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_boot_sequencer;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic        abort;
    logic [9:0]  imem_len;
    logic [10:0] dmem_len;
    logic [31:0] run_len;
    logic        s_valid;
    logic [63:0] s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    cpu_boot_sequencer #(
        .IMEM_ADDR_W(9),
        .DMEM_ADDR_W(10),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .abort      (abort),
        .imem_len   (imem_len),
        .dmem_len   (dmem_len),
        .run_len    (run_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .wdata_ext  (wdata_ext),
        .addr_ext_2 (addr_ext_2),
        .wen_ext_2  (wen_ext_2),
        .wdata_ext_2(wdata_ext_2),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ilen;
        int dlen;
        int rlen;
        bit toggle;   // s_valid every other cycle
        bit poke;     // pulse start while busy
        int exp_iw;
        int exp_dw;
        int exp_en;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mkword(input int n);
        return {32'hC0DE_0000 + 32'(n), 32'h0000_00A0 + 32'(n)};
    endfunction

    task automatic run_vec(input vec_t v);
        int  n_acc    = 0;
        int  iw       = 0;
        int  dw       = 0;
        int  en       = 0;
        int  cyc      = 0;
        bit  prev_acc = 0;
        int  prev_n   = 0;
        bit  got_done = 0;
        int  ilen_eff;
        ilen_eff = (v.ilen > 512) ? 512 : v.ilen;

        imem_len = 10'(v.ilen);
        dmem_len = 11'(v.dlen);
        run_len  = 32'(v.rlen);
        s_valid  = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        while (!got_done && cyc < 5000) begin
            chk("wen_ext_latency", wen_ext, prev_acc && (prev_n < ilen_eff));
            chk("wen_ext_2_latency", wen_ext_2, prev_acc && (prev_n >= ilen_eff));
            if (wen_ext) begin
                iw++;
                chk("addr_ext", addr_ext, 64'(prev_n * 4));
                chk("wdata_ext", wdata_ext, {32'h0, mkword(prev_n) & 64'hFFFF_FFFF});
            end
            if (wen_ext_2) begin
                dw++;
                chk("addr_ext_2", addr_ext_2, 64'((prev_n - ilen_eff) * 8));
                chk("wdata_ext_2", wdata_ext_2, mkword(prev_n));
            end
            if (cpu_enable) en++;
            if (done) got_done = 1;

            s_valid  = v.toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data   = mkword(n_acc);
            start    = v.poke && busy && ((cyc % 3) == 0);
            prev_acc = s_valid && s_ready;
            prev_n   = n_acc;
            if (prev_acc) n_acc++;
            @(posedge clk); #1;
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;

        chk("done_reached", 64'(got_done), 64'd1);
        chk("imem_writes", 64'(iw), 64'(v.exp_iw));
        chk("dmem_writes", 64'(dw), 64'(v.exp_dw));
        chk("enable_cycles", 64'(en), 64'(v.exp_en));
        chk("beats_accepted", 64'(n_acc), 64'(v.exp_iw + v.exp_dw));
        chk("busy_at_done", busy, 1'b0);
    endtask

    initial begin
        //            ilen  dlen  rlen tog poke  iw    dw  en
        vecs[0] = '{    3,    2,    5,  0,  0,   3,    2,  5};
        vecs[1] = '{    3,    2,    5,  1,  0,   3,    2,  5};
        vecs[2] = '{    0,    0,    0,  0,  0,   0,    0,  0};
        vecs[3] = '{    2,    0,    1,  0,  0,   2,    0,  1};
        vecs[4] = '{    0,    3,    2,  1,  0,   0,    3,  2};
        vecs[5] = '{    0,    0,    4,  0,  0,   0,    0,  4};
        vecs[6] = '{  600,    1,    0,  0,  0, 512,    1,  0};
        vecs[7] = '{    1, 2047,    3,  0,  0,   1, 1024,  3};
        vecs[8] = '{    0,    0,   10,  0,  1,   0,    0, 10};

        arst_n   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        imem_len = '0;
        dmem_len = '0;
        run_len  = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {s_ready, wen_ext, wen_ext_2, cpu_enable, busy, done}, 6'b0);
        chk("reset_addr", addr_ext, 64'd0);
        chk("reset_addr_2", addr_ext_2, 64'd0);
        chk("reset_wdata", wdata_ext, 32'd0);
        chk("reset_wdata_2", wdata_ext_2, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Empty sequence reaches DONE one cycle after start.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("empty_done", done, 1'b1);
        chk("empty_busy", busy, 1'b0);
        // Restart from DONE: done drops in the very next cycle.
        imem_len = 10'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_done_drop", done, 1'b0);
        chk("restart_ready", s_ready, 1'b1);

        // Abort together with acceptance of the second imem beat.
        s_valid = 1'b1;
        s_data  = mkword(0);
        @(posedge clk); #1;
        chk("abort_first_wen", wen_ext, 1'b1);
        chk("abort_first_data", wdata_ext, 32'h0000_00A0);
        s_data = mkword(1);
        abort  = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("abort_wen_suppressed", wen_ext, 1'b0);
        chk("abort_ctrl", {s_ready, cpu_enable, busy, done}, 4'b0);
        chk("abort_addr_hold", addr_ext, 64'd0);
        chk("abort_data_hold", wdata_ext, 32'h0000_00A0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of RUN.
        imem_len = '0;
        dmem_len = '0;
        run_len  = 32'd10;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_enable", cpu_enable, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        chk("arst_ctrl", {s_ready, wen_ext, wen_ext_2, cpu_enable, busy, done}, 6'b0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_stays_idle", {cpu_enable, busy, done}, 3'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_boot_sequencer.md
Name: cpu_boot_sequencer

Overview:
- Load-and-run controller placed in front of the cpu top level.
- Accepts a valid/ready word stream and writes it into instruction memory through the external port (addr_ext/wen_ext/wdata_ext), then into data memory through the second external port (addr_ext_2/wen_ext_2/wdata_ext_2).
- Then drives the cpu enable for a programmed number of cycles and reports completion.
- Owns the external memory ports exclusively while not idle.

Parameters:
IMEM_ADDR_W, 9, instruction-memory word-address width; max program = 2^IMEM_ADDR_W words
DMEM_ADDR_W, 10, data-memory word-address width; max data image = 2^DMEM_ADDR_W words
CNT_W, 32, width of run-cycle counter

Ports:
clk  in  1  main clock
arst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled in IDLE or DONE only
abort  in  1  synchronous abort; highest priority after reset
imem_len  in  IMEM_ADDR_W+1  instruction words to load (sampled at start)
dmem_len  in  DMEM_ADDR_W+1  data words to load (sampled at start)
run_len  in  CNT_W  cpu enable cycles (sampled at start)
s_valid  in  1  stream word valid
s_data  in  64  stream word; imem phase uses [31:0]
s_ready  out  1  stream ready
addr_ext  out  64  imem external byte address
wen_ext  out  1  imem external write enable
wdata_ext  out  32  imem external write data
addr_ext_2  out  64  dmem external byte address
wen_ext_2  out  1  dmem external write enable
wdata_ext_2  out  64  dmem external write data
cpu_enable  out  1  cpu enable
busy  out  1  high in LOAD_I, LOAD_D, RUN
done  out  1  high in DONE

Behaviour:
- Reset: state = IDLE. Every output is 0, including all addresses and write data. All counters are 0.
- States: IDLE, LOAD_I, LOAD_D, RUN, DONE. State and all outputs are registered.
- s_ready is a registered state decode: 1 exactly in LOAD_I and LOAD_D.
- A beat is accepted when s_valid & s_ready. s_data is ignored otherwise.
- IDLE or DONE with start=1:
  - Latch imem_len, dmem_len and run_len.
  - Clear the word index.
  - Go to the first non-empty phase in order LOAD_I, LOAD_D, RUN; if all three lengths are 0, go to DONE.
  - done drops in the cycle after start is sampled.
- LOAD_I, on each accepted beat k (k from 0):
  - Next cycle: wen_ext=1 for exactly one cycle, addr_ext = k*4 (zero-extended to 64), wdata_ext = s_data[31:0].
  - After accepting beat imem_len-1, go to LOAD_D (or RUN/DONE if later lengths are 0) and reset the index.
  - The final write pulse still occurs in the cycle after that beat's acceptance.
- LOAD_D: same as LOAD_I, but wen_ext_2 pulses with addr_ext_2 = k*8 and wdata_ext_2 = s_data.
- Write latency is 1 cycle from acceptance. Back-to-back beats give back-to-back write pulses. Stream bubbles give no pulse.
- Addresses and write data hold their last value when wen is 0.
- wen_ext and wen_ext_2 are never high in the same cycle.
- RUN:
  - cpu_enable=1 for exactly run_len consecutive cycles, counted with a CNT_W down-counter.
  - The cycle after the last enabled cycle, go to DONE with cpu_enable=0.
  - No write enables are asserted in RUN.
- DONE: done=1 until start is sampled; then behave as from IDLE.
- start while busy is ignored.
- Full length (imem_len = 2^IMEM_ADDR_W): the index reaches the top word without wrap. Lengths above the maximum are clamped to the maximum at latch.
- Abort in any state:
  - Next cycle: state = IDLE, s_ready=0, cpu_enable=0, busy=0, done=0.
  - A write pulse already scheduled from a beat accepted in the abort cycle is suppressed.
  - Addresses and data keep their values.
- Abort and start in the same cycle: abort wins.
- arst_n low mid-operation: immediate return to reset values, no partial pulse.

Test Plan:
1. imem_len=3, dmem_len=2, run_len=5, continuous valid, words 0xA0..0xA4 -> wen_ext pulses at addresses 0,4,8 with data 0xA0,0xA1,0xA2; then wen_ext_2 at addresses 0,8 with 0xA3,0xA4; then cpu_enable high exactly 5 cycles; then done=1, busy=0.
2. Same lengths with s_valid toggling every other cycle -> one write pulse per accepted beat, each 1 cycle after acceptance; addresses contiguous; no extra pulses.
3. imem_len=0, dmem_len=0, run_len=0, start -> DONE one cycle later; no write pulses; cpu_enable never high.
4. imem_len=2, dmem_len=0, run_len=1 -> LOAD_D skipped; exactly 2 imem writes, then cpu_enable high 1 cycle.
5. Abort asserted on acceptance of the 2nd imem beat -> only the first write occurs; next cycle state is IDLE with all control outputs 0; a subsequent start reloads from address 0.
6. arst_n pulsed low during RUN -> cpu_enable, busy and done 0 asynchronously; start while busy (run_len=10) has no effect on the cycle count.
